// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution partial-sum output stage
package conv_pkg;

  typedef enum logic {ACCUM, EMIT} psum_state_t;

  // Clamp a sign-extended value into the signed range of a res-bit word.
  function automatic logic signed [63:0] sat_res(input logic signed [63:0] v, input int res);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (res - 1)) - 64'sd1;
    lo = ~hi;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

endpackage

// File: rtl/GenericCounter.sv
// GenericCounter: wrapping 0..COUNTER_SIZE counter with a clear that takes priority over the step
module GenericCounter #(
  parameter int COUNTER_SIZE = 3,
  parameter int W = $clog2(COUNTER_SIZE + 1) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d, base;

  // Clear rebases to zero first, so an enable in the same cycle counts from zero.
  always_comb begin
    base = clear ? '0 : count_q;
    wrap = en && base == W'(COUNTER_SIZE);
    count_d = !en ? base : wrap ? '0 : base + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/conv_out_fifo.sv
// conv_out_fifo: synchronous FIFO with registered full/empty flags and push-while-full-with-pop
module conv_out_fifo #(
  parameter int W = 24,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic full_q, full_d, empty_q, empty_d, do_push, do_pop;

  // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds alongside it.
  always_comb begin
    do_pop = pop && !empty_q;
    do_push = push && (!full_q || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d = cnt_d == (AW+1)'(DEPTH);
    empty_d = cnt_d == '0;
  end

  // Storage, pointers and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end

  assign dout = mem_q[rd_q];
  assign full = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/conv_psum_output_stage.sv
// conv_psum_output_stage: sums per-channel accumulators, requantizes and queues result words
module conv_psum_output_stage
  import conv_pkg::*;
#(
  parameter int Pix = 3,
  parameter int RES = 8,
  parameter int ACC = 16,
  parameter int CIN = 4,
  parameter int SHIFT = 0,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(CIN) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [RES-1:0] acc_in [Pix],
  input  logic                  acc_valid,
  input  logic                  psum_clear,
  input  logic signed [RES-1:0] bias,
  input  logic                  relu_en,
  output logic signed [RES-1:0] out_data [Pix],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  in_ready,
  output logic [CW-1:0]         ch_index,
  output logic                  overflow
);

  psum_state_t state_q, state_d;
  logic signed [ACC-1:0] psum_q [Pix];
  logic signed [ACC-1:0] psum_d [Pix];
  logic [Pix*RES-1:0] word, head;
  logic wrap, push, fifo_full, fifo_empty, overflow_q, overflow_d;
  logic signed [ACC:0] t;
  logic signed [63:0] s;

  GenericCounter #(.COUNTER_SIZE(CIN - 1), .W(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (psum_clear),
    .en    (acc_valid),
    .count (ch_index),
    .wrap  (wrap)
  );

  // Channel 0 (or a cleared group) starts a fresh sum; the sum wraps at ACC bits.
  always_comb begin
    for (int i = 0; i < Pix; i++)
      psum_d[i] = acc_valid ? ((psum_clear || ch_index == '0) ? '0 : psum_q[i])
                              + {{(ACC-RES){acc_in[i][RES-1]}}, acc_in[i]} : psum_q[i];
  end

  // Partial-sum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < Pix; i++) psum_q[i] <= '0;
    else psum_q <= psum_d;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else state_q <= state_d;
  end

  // The last channel of a group always leads into a one-cycle EMIT, even from EMIT itself.
  always_comb state_d = wrap ? EMIT : ACCUM;

  // EMIT output: bias, shift, optional ReLU and saturation on the pre-edge partial sums.
  always_comb begin
    push = state_q == EMIT;
    word = '0;
    t = '0;
    s = '0;
    for (int i = 0; i < Pix; i++) begin
      t = {psum_q[i][ACC-1], psum_q[i]} + {{(ACC+1-RES){bias[RES-1]}}, bias};
      t = t >>> SHIFT;
      t = (relu_en && t < 0) ? '0 : t;
      s = sat_res({{(63-ACC){t[ACC]}}, t}, RES);
      word[i*RES +: RES] = s[RES-1:0];
    end
  end

  // A word pushed into a full FIFO with no pop pending is lost; remember that until reset.
  always_comb overflow_d = overflow_q || (push && fifo_full && !out_ready);

  // Sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else overflow_q <= overflow_d;
  end

  conv_out_fifo #(.W(Pix * RES), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (word),
    .pop   (out_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Unpack the FIFO head into lanes.
  always_comb begin
    for (int i = 0; i < Pix; i++) out_data[i] = head[i*RES +: RES];
  end

  assign out_valid = !fifo_empty;
  assign in_ready = !fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_conv_psum_output_stage.sv
// tb_conv_psum_output_stage: scoreboard bench over two configurations of the output stage
module tb_conv_psum_output_stage;

  localparam int P = 3;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic signed [R-1:0] a_in [P];
  logic signed [R-1:0] a_out [P];
  logic signed [R-1:0] b_in [P];
  logic signed [R-1:0] b_out [P];
  logic signed [R-1:0] a_bias = '0, b_bias = '0;
  logic a_v = 0, a_clr = 0, a_relu = 0, a_ready = 1, a_ov, a_ir, a_ovf;
  logic b_v = 0, b_clr = 0, b_relu = 0, b_ready = 1, b_ov, b_ir, b_ovf;
  logic [1:0] a_ch;
  logic [0:0] b_ch;
  logic [23:0] a_word, b_word;
  logic [23:0] qa [$];
  logic [23:0] qb [$];
  int n_chk = 0, n_fail = 0;

  assign a_word = {a_out[2], a_out[1], a_out[0]};
  assign b_word = {b_out[2], b_out[1], b_out[0]};

  conv_psum_output_stage #(.Pix(P), .RES(R), .ACC(16), .CIN(2), .SHIFT(0), .DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .acc_in(a_in), .acc_valid(a_v), .psum_clear(a_clr),
    .bias(a_bias), .relu_en(a_relu), .out_data(a_out), .out_valid(a_ov),
    .out_ready(a_ready), .in_ready(a_ir), .ch_index(a_ch), .overflow(a_ovf)
  );

  conv_psum_output_stage #(.Pix(P), .RES(R), .ACC(16), .CIN(1), .SHIFT(2), .DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .acc_in(b_in), .acc_valid(b_v), .psum_clear(b_clr),
    .bias(b_bias), .relu_en(b_relu), .out_data(b_out), .out_valid(b_ov),
    .out_ready(b_ready), .in_ready(b_ir), .ch_index(b_ch), .overflow(b_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lane(input int sum, input int bias, input bit relu, input int sh);
    int t;
    t = (sum + bias) >>> sh;
    if (relu && t < 0) t = 0;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t[7:0];
  endfunction

  function automatic logic [23:0] exp_word(input int s0, input int s1, input int s2,
                                           input int bias, input bit relu, input int sh);
    return {lane(s2, bias, relu, sh), lane(s1, bias, relu, sh), lane(s0, bias, relu, sh)};
  endfunction

  task automatic pulse_a(input int v0, input int v1, input int v2, input bit clr);
    @(posedge clk); #1;
    a_in[0] = 8'(v0); a_in[1] = 8'(v1); a_in[2] = 8'(v2);
    a_v = 1; a_clr = clr;
    @(posedge clk); #1;
    a_v = 0; a_clr = 0;
  endtask

  task automatic pulse_b(input int v0, input int v1, input int v2);
    @(posedge clk); #1;
    b_in[0] = 8'(v0); b_in[1] = 8'(v1); b_in[2] = 8'(v2);
    b_v = 1;
    @(posedge clk); #1;
    b_v = 0;
  endtask

  task automatic burst_b(input int n, input int gap);
    logic signed [7:0] r [3];
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        r[j] = 8'($urandom_range(255));
        b_in[j] = r[j];
      end
      b_v = 1;
      b_ready = ~b_ready;
      qb.push_back(exp_word(int'(r[0]), int'(r[1]), int'(r[2]), int'(b_bias), 0, 2));
    end
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
      b_v = 0;
      b_ready = ~b_ready;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_valid"}, a_ov, 0);
    check({tag, "_a_inrdy"}, a_ir, 1);
    check({tag, "_a_ovf"}, a_ovf, 0);
    check({tag, "_a_ch"}, a_ch, 0);
    check({tag, "_a_data"}, a_word, 0);
    check({tag, "_b_valid"}, b_ov, 0);
    check({tag, "_b_inrdy"}, b_ir, 1);
    check({tag, "_b_ovf"}, b_ovf, 0);
    check({tag, "_b_data"}, b_word, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ov && a_ready) begin
        check("a_expected", qa.size() != 0, 1);
        if (qa.size() != 0) check("a_data", a_word, qa.pop_front());
      end
      if (b_ov && b_ready) begin
        check("b_expected", qb.size() != 0, 1);
        if (qb.size() != 0) check("b_data", b_word, qb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < P; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 check_reset("rst");
    rst_n = 1;

    qa.push_back(exp_word(5, 7, 9, 0, 0, 0));
    pulse_a(1, 2, 3, 0);
    check("a_ch_one", a_ch, 1);
    pulse_a(4, 5, 6, 0);
    check("a_ch_wrap", a_ch, 0);
    @(negedge clk) check("lat_emit", a_ov, 0);
    @(negedge clk) check("lat_valid", a_ov, 1);
    repeat (2) @(negedge clk);

    a_bias = 10;
    qa.push_back(exp_word(200, -200, 100, 10, 0, 0));
    pulse_a(100, -100, 50, 0);
    pulse_a(100, -100, 50, 0);
    repeat (3) @(negedge clk);
    a_relu = 1;
    qa.push_back(exp_word(200, -200, 100, 10, 1, 0));
    pulse_a(100, -100, 50, 0);
    pulse_a(100, -100, 50, 0);
    repeat (3) @(negedge clk);
    a_relu = 0;
    a_bias = 0;

    pulse_a(9, 9, 9, 0);
    check("clr_pre", a_ch, 1);
    @(posedge clk); #1 a_clr = 1;
    @(posedge clk); #1 a_clr = 0;
    check("clr_ch", a_ch, 0);
    qa.push_back(exp_word(2, 2, 2, 0, 0, 0));
    pulse_a(1, 1, 1, 0);
    pulse_a(1, 1, 1, 0);
    repeat (3) @(negedge clk);

    pulse_a(50, 50, 50, 0);
    qa.push_back(exp_word(7, 7, 7, 0, 0, 0));
    pulse_a(3, 3, 3, 1);
    check("clr_pulse_ch", a_ch, 1);
    pulse_a(4, 4, 4, 0);
    repeat (3) @(negedge clk);

    @(posedge clk); #1 a_ready = 0;
    qa.push_back(exp_word(11, 21, 31, 0, 0, 0));
    pulse_a(10, 20, 30, 0);
    pulse_a(1, 1, 1, 0);
    qa.push_back(exp_word(-6, 0, 6, 0, 0, 0));
    pulse_a(-5, 0, 5, 0);
    pulse_a(-1, 0, 1, 0);
    repeat (2) @(negedge clk);
    check("full_inrdy", a_ir, 0);
    check("full_no_ovf", a_ovf, 0);
    pulse_a(7, 7, 7, 0);
    pulse_a(7, 7, 7, 0);
    repeat (2) @(negedge clk);
    check("drop_ovf", a_ovf, 1);
    check("stall_head", a_word, qa[0]);
    @(posedge clk); #1 a_ready = 1;
    repeat (4) @(negedge clk);
    check("ovf_sticky", a_ovf, 1);
    check("a_drained", qa.size(), 0);

    b_bias = 1;
    qb.push_back(exp_word(-7, 9, 0, 1, 0, 2));
    pulse_b(-7, 9, 0);
    repeat (3) @(negedge clk);

    for (int g = 0; g < 4; g++) burst_b(3, 6 + g % 2);
    check("b_drained", qb.size(), 0);
    check("b_no_ovf", b_ovf, 0);

    burst_b(2, 0);
    @(posedge clk); #3 rst_n = 0;
    #1 check_reset("async");
    b_v = 0;
    qa.delete();
    qb.delete();
    @(posedge clk); #1 rst_n = 1;
    b_ready = 1;
    qb.push_back(exp_word(40, -40, 4, 1, 0, 2));
    pulse_b(40, -40, 4);
    repeat (3) @(negedge clk);
    check("post_rst_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
